// File: rtl/ram_dualport_param.sv
// True dual-port RAM with width/depth parameters, optional output register, a collision flag
// and a sweep engine that writes INIT_VAL everywhere after reset or on clr_req.

module ram_dualport_param #(
   parameter int                DATA_W   = 8,
   parameter int                ADDR_W   = 7,
   parameter logic [DATA_W-1:0] INIT_VAL = '0,
   parameter bit                READ_NEW = 1'b0,
   parameter bit                OUT_REG  = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_req,
   input  logic              a_en,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic [DATA_W-1:0] a_rdata,
   output logic              a_rvalid,
   input  logic              b_en,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic [DATA_W-1:0] b_rdata,
   output logic              b_rvalid,
   output logic              init_busy,
   output logic              collision
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] sweep_addr;
   logic              sweep_last;
   logic              run;

   logic              same_addr;
   logic              a_wr, a_rd, b_wr, b_rd, b_wr_ok;
   logic              coll_now;
   logic [DATA_W-1:0] a_rd_word, b_rd_word;

   logic [DATA_W-1:0] a_q_dat, b_q_dat;
   logic              a_q_vld, b_q_vld;

   logic [DATA_W-1:0] mem [DEPTH];

   assign sweep_last = (sweep_addr == {ADDR_W{1'b1}});

   // State register; sweep address only advances while clearing and parks at 0 otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_CLEAR;
         sweep_addr <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_CLEAR) sweep_addr <= sweep_addr + ADDR_W'(1);
         else                   sweep_addr <= '0;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_CLEAR: if (sweep_last) state_nxt = ST_RUN;
         ST_RUN:   if (clr_req)    state_nxt = ST_CLEAR;
         default:  state_nxt = ST_CLEAR;
      endcase
   end

   always_comb begin
      init_busy = 1'b0;
      run       = 1'b0;
      case (state)
         ST_CLEAR: init_busy = 1'b1;
         ST_RUN:   run       = 1'b1;
         default:  init_busy = 1'b1;
      endcase
   end

   assign same_addr = (a_addr == b_addr);
   assign a_wr      = run & a_en & a_we;
   assign a_rd      = run & a_en & ~a_we;
   assign b_wr      = run & b_en & b_we;
   assign b_rd      = run & b_en & ~b_we;
   // Port A wins a write-write conflict on the same word.
   assign b_wr_ok   = b_wr & ~(a_wr & same_addr);
   assign coll_now  = run & a_en & b_en & same_addr & (a_we | b_we);

   assign a_rd_word = (READ_NEW && b_wr && same_addr) ? b_wdata : mem[a_addr];
   assign b_rd_word = (READ_NEW && a_wr && same_addr) ? a_wdata : mem[b_addr];

   always_ff @(posedge clk) begin
      if (init_busy) begin
         mem[sweep_addr] <= INIT_VAL;
      end else begin
         if (a_wr)    mem[a_addr] <= a_wdata;
         if (b_wr_ok) mem[b_addr] <= b_wdata;
      end
   end

   // First read stage; data only updates on a read so rdata holds across writes and idles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q_dat   <= '0;
         b_q_dat   <= '0;
         a_q_vld   <= 1'b0;
         b_q_vld   <= 1'b0;
         collision <= 1'b0;
      end else begin
         a_q_vld   <= a_rd;
         b_q_vld   <= b_rd;
         collision <= coll_now;
         if (a_rd) a_q_dat <= a_rd_word;
         if (b_rd) b_q_dat <= b_rd_word;
      end
   end

   generate
      if (OUT_REG) begin : g_oreg
         logic [DATA_W-1:0] a_o_dat, b_o_dat;
         logic              a_o_vld, b_o_vld;

         // Not gated by init_busy, so a read caught in flight by a clear still completes.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_o_dat <= '0;
               b_o_dat <= '0;
               a_o_vld <= 1'b0;
               b_o_vld <= 1'b0;
            end else begin
               a_o_vld <= a_q_vld;
               b_o_vld <= b_q_vld;
               if (a_q_vld) a_o_dat <= a_q_dat;
               if (b_q_vld) b_o_dat <= b_q_dat;
            end
         end

         assign a_rdata  = a_o_dat;
         assign a_rvalid = a_o_vld;
         assign b_rdata  = b_o_dat;
         assign b_rvalid = b_o_vld;
      end else begin : g_noreg
         assign a_rdata  = a_q_dat;
         assign a_rvalid = a_q_vld;
         assign b_rdata  = b_q_dat;
         assign b_rvalid = b_q_vld;
      end
   endgenerate

endmodule
